dram_port_arbiter: RTL and testbench
====================================

# dram_port_arbiter

Shares the two ports of the monitoring system's dual-port trace RAM (one-cycle registered read, write-through on the writing port) among `N_REQ` requesters. Each cycle it grants up to two requests in round-robin order, steering the first grant to RAM port 1 and the second to RAM port 2. It resolves same-address hazards by deferring the second request, and routes read data back to the issuing requester one cycle after grant.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `WORD_SIZE`, 64: data width.
- `ADDR_SIZE`, 8: address width.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input N_REQ: request pending, one bit per requester.
- `req_we` input N_REQ: 1 = write, 0 = read.
- `req_addr` input N_REQ*ADDR_SIZE: requester i occupies bits [i*ADDR_SIZE +: ADDR_SIZE].
- `req_wdata` input N_REQ*WORD_SIZE: write data, packed the same way.
- `req_ready` output N_REQ: grant; a transfer occurs when valid&ready are high at a rising edge.
- `rsp_valid` output N_REQ: read data valid for requester i.
- `rsp_rdata` output N_REQ*WORD_SIZE: read data, packed per requester.
- `ram_we_1`, `ram_we_2` output 1: RAM write enables.
- `ram_addr_1`, `ram_addr_2` output ADDR_SIZE: RAM addresses.
- `ram_wdata_1`, `ram_wdata_2` output WORD_SIZE: RAM write data.
- `ram_rdata_1`, `ram_rdata_2` input WORD_SIZE: RAM registered outputs.
- `stat_grants` output 32: total granted transfers.
- `stat_stalls` output 32: hazard deferrals.

## Operation
**Round-robin scan**
- Starts at pointer `rr_ptr`, wraps modulo N_REQ.
- The first valid requester found is A and goes to port 1.
- The next valid requester found is B and goes to port 2.
- Zero, one or two grants per cycle.

**Hazard rule**
- B is not granted if addr(B)==addr(A) and either request is a write. B stays pending with `req_ready`=0.
- Two reads to the same address are both granted.
- When B is deferred, the scan does not look for a later requester in the same cycle.

**Port drive**
- A port with no grant drives we=0, addr=0, wdata=0.

**Pointer update**
- `rr_ptr` moves to (index of last granted requester + 1) mod N_REQ.
- If nothing is granted, `rr_ptr` holds.
- Guarantee: every continuously valid requester is granted within N_REQ cycles.

**Read return**
- Per port, register `{owner index, was_read}` at grant.
- Next cycle: `rsp_valid[owner]`=1 for one cycle, with `rsp_rdata[owner]` = that port's `ram_rdata`.
- Writes produce no response.
- Requesters may issue back-to-back; each read has exactly one response.

**Statistics**
- `stat_grants` adds the number of grants each cycle (0/1/2).
- `stat_stalls` increments on each deferral.
- Both counters saturate at 2^32-1.

## Timing
- `req_ready` is combinational from `req_valid`/`req_we`/`req_addr` and `rr_ptr`. The `ram_*` outputs are combinational from the grant, so the RAM samples on the same edge as the handshake.
- Read latency: grant at edge T means `rsp_valid` is high in the cycle following T, for exactly one cycle. Fully pipelined, one response per port per cycle.
- `rsp_rdata` for a requester is don't-care when its `rsp_valid`=0; the bench must not check it.
- `req_ready` may only rise when `req_valid` is high. Requesters hold addr/data/we stable until granted.
- Reset values (while `rst_n`=0): `req_ready`=0, all `ram_*`=0, `rsp_valid`=0, `rr_ptr`=0, stat counters 0.
- Reset asserted mid-operation: in-flight responses are dropped and no `rsp_valid` follows.
- First grant after release: the first edge with `rst_n`=1.

## Configuration
**`DRAM_ARB_STATS_EN` defined**
- Counters implemented as described.

**`DRAM_ARB_STATS_EN` undefined**
- The counter logic is removed.
- `stat_grants` and `stat_stalls` are tied to 0. The ports still exist.
- Arbitration is unchanged.

## Test plan
- **Reset:** assert `rst_n`=0 mid-read, with `rsp_valid` expected next cycle -> no `rsp_valid`; all outputs 0; after release, req0 read of 0x10 is granted on port 1 at the first edge.
- **Round robin:** all four requesters issue continuous reads at distinct addresses -> grant pairs (0,1), (2,3), (0,1)…; each `rsp_valid` appears one cycle after its grant with the preloaded data.
- **Write hazard:** req0 writes 0x05 with 0xAA, req1 reads 0x05 in the same cycle -> only req0 granted, `stat_stalls`=1; req1 granted next cycle and gets `rsp_rdata`=0xAA.
- **Read sharing:** req2 and req3 both read 0x20, holding 0x1234 -> both granted in one cycle, both `rsp_valid` next cycle with 0x1234, `stat_stalls`=0.
- **Wrap and fairness:** req3 and req0 valid with `rr_ptr`=3 -> req3 on port 1, req0 on port 2, `rr_ptr` becomes 1; 1000 random cycles -> no requester waits more than 4 cycles; `stat_grants` equals the number of issued transfers (0 when the macro is undefined).

Source files
------------

// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_port_arbiter
// Summary  : Round-robin arbiter that grants up to two requesters per cycle
//            onto the two ports of a dual-port trace RAM and routes read data
//            back to the issuer. Statistics counters exist only when
//            DRAM_ARB_STATS_EN is defined; otherwise they read as zero.
// Revision : 1.0 - initial release
// ============================================================================
module dram_port_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WORD_SIZE = 64,
    parameter int ADDR_SIZE = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_we,
    input  logic [N_REQ*ADDR_SIZE-1:0] req_addr,
    input  logic [N_REQ*WORD_SIZE-1:0] req_wdata,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [N_REQ*WORD_SIZE-1:0] rsp_rdata,
    output logic                       ram_we_1,
    output logic                       ram_we_2,
    output logic [ADDR_SIZE-1:0]       ram_addr_1,
    output logic [ADDR_SIZE-1:0]       ram_addr_2,
    output logic [WORD_SIZE-1:0]       ram_wdata_1,
    output logic [WORD_SIZE-1:0]       ram_wdata_2,
    input  logic [WORD_SIZE-1:0]       ram_rdata_1,
    input  logic [WORD_SIZE-1:0]       ram_rdata_2,
    output logic [31:0]                stat_grants,
    output logic [31:0]                stat_stalls
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]     r_rr_ptr;
    logic                 r_rsp1_vld;
    logic                 r_rsp2_vld;
    logic [PTR_W-1:0]     r_rsp1_own;
    logic [PTR_W-1:0]     r_rsp2_own;

    logic                 w_found_a;
    logic                 w_found_b;
    logic [PTR_W-1:0]     w_a_idx;
    logic [PTR_W-1:0]     w_b_idx;
    logic [ADDR_SIZE-1:0] w_addr_a;
    logic [ADDR_SIZE-1:0] w_addr_b;
    logic [WORD_SIZE-1:0] w_wdata_a;
    logic [WORD_SIZE-1:0] w_wdata_b;
    logic                 w_we_a;
    logic                 w_we_b;
    logic                 w_hazard;
    logic                 w_grant_b;
    logic [PTR_W-1:0]     w_last_idx;
    logic [PTR_W-1:0]     w_next_ptr;

    // Scan from the pointer; A is the first valid requester, B the next one.
    // Nothing past B is ever considered, so a deferred B blocks the rest.
    always_comb begin
        int               pos;
        logic [PTR_W-1:0] idx;
        w_found_a = 1'b0;
        w_found_b = 1'b0;
        w_a_idx   = '0;
        w_b_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(r_rr_ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            idx = PTR_W'(pos);
            if (rst_n && req_valid[idx]) begin
                if (!w_found_a) begin
                    w_found_a = 1'b1;
                    w_a_idx   = idx;
                end else if (!w_found_b) begin
                    w_found_b = 1'b1;
                    w_b_idx   = idx;
                end
            end
        end
    end

    assign w_addr_a  = req_addr[w_a_idx*ADDR_SIZE +: ADDR_SIZE];
    assign w_addr_b  = req_addr[w_b_idx*ADDR_SIZE +: ADDR_SIZE];
    assign w_wdata_a = req_wdata[w_a_idx*WORD_SIZE +: WORD_SIZE];
    assign w_wdata_b = req_wdata[w_b_idx*WORD_SIZE +: WORD_SIZE];
    assign w_we_a    = req_we[w_a_idx];
    assign w_we_b    = req_we[w_b_idx];

    // Same-address pairs are only safe when both sides are reads.
    assign w_hazard  = w_found_b && (w_addr_a == w_addr_b) && (w_we_a || w_we_b);
    assign w_grant_b = w_found_b && !w_hazard;

    always_comb begin
        req_ready = '0;
        if (w_found_a) begin
            req_ready[w_a_idx] = 1'b1;
        end
        if (w_grant_b) begin
            req_ready[w_b_idx] = 1'b1;
        end
    end

    assign ram_we_1    = w_found_a && w_we_a;
    assign ram_addr_1  = w_found_a ? w_addr_a : '0;
    assign ram_wdata_1 = (w_found_a && w_we_a) ? w_wdata_a : '0;
    assign ram_we_2    = w_grant_b && w_we_b;
    assign ram_addr_2  = w_grant_b ? w_addr_b : '0;
    assign ram_wdata_2 = (w_grant_b && w_we_b) ? w_wdata_b : '0;

    assign w_last_idx  = w_grant_b ? w_b_idx : w_a_idx;
    assign w_next_ptr  = (w_last_idx == PTR_W'(N_REQ - 1)) ? '0 : (w_last_idx + PTR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_rsp1_vld <= 1'b0;
            r_rsp2_vld <= 1'b0;
            r_rsp1_own <= '0;
            r_rsp2_own <= '0;
        end else begin
            if (w_found_a) begin
                r_rr_ptr <= w_next_ptr;
            end
            r_rsp1_vld <= w_found_a && !w_we_a;
            r_rsp1_own <= w_a_idx;
            r_rsp2_vld <= w_grant_b && !w_we_b;
            r_rsp2_own <= w_b_idx;
        end
    end

    // A and B are always distinct requesters, so at most one port hits each.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
            logic w_hit1;
            logic w_hit2;
            assign w_hit1        = r_rsp1_vld && (r_rsp1_own == PTR_W'(gi));
            assign w_hit2        = r_rsp2_vld && (r_rsp2_own == PTR_W'(gi));
            assign rsp_valid[gi] = w_hit1 || w_hit2;
            assign rsp_rdata[gi*WORD_SIZE +: WORD_SIZE] = w_hit1 ? ram_rdata_1 : ram_rdata_2;
        end
    endgenerate

`ifdef DRAM_ARB_STATS_EN
    logic [31:0] r_stat_grants;
    logic [31:0] r_stat_stalls;
    logic [1:0]  w_n_grants;
    logic [32:0] w_grant_sum;

    assign w_n_grants  = {1'b0, w_found_a} + {1'b0, w_grant_b};
    assign w_grant_sum = {1'b0, r_stat_grants} + {31'd0, w_n_grants};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_grants <= '0;
            r_stat_stalls <= '0;
        end else begin
            r_stat_grants <= w_grant_sum[32] ? 32'hFFFF_FFFF : w_grant_sum[31:0];
            if (w_hazard && (r_stat_stalls != 32'hFFFF_FFFF)) begin
                r_stat_stalls <= r_stat_stalls + 32'd1;
            end
        end
    end

    assign stat_grants = r_stat_grants;
    assign stat_stalls = r_stat_stalls;
`else
    assign stat_grants = '0;
    assign stat_stalls = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_port_arbiter
// Summary  : Directed and random checks of dram_port_arbiter against a
//            behavioural dual-port RAM and hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_port_arbiter;

    localparam int N = 4;
    localparam int W = 64;
    localparam int A = 8;

`ifdef DRAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_we;
    logic [N*A-1:0] req_addr;
    logic [N*W-1:0] req_wdata;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [N*W-1:0] rsp_rdata;
    logic           ram_we_1, ram_we_2;
    logic [A-1:0]   ram_addr_1, ram_addr_2;
    logic [W-1:0]   ram_wdata_1, ram_wdata_2;
    logic [W-1:0]   ram_rdata_1, ram_rdata_2;
    logic [31:0]    stat_grants, stat_stalls;

    int vectors     = 0;
    int miscompares = 0;

    dram_port_arbiter #(.N_REQ(N), .WORD_SIZE(W), .ADDR_SIZE(A)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .ram_we_1    (ram_we_1),
        .ram_we_2    (ram_we_2),
        .ram_addr_1  (ram_addr_1),
        .ram_addr_2  (ram_addr_2),
        .ram_wdata_1 (ram_wdata_1),
        .ram_wdata_2 (ram_wdata_2),
        .ram_rdata_1 (ram_rdata_1),
        .ram_rdata_2 (ram_rdata_2),
        .stat_grants (stat_grants),
        .stat_stalls (stat_stalls)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int a);
        return (a == 32'h20) ? 64'h1234 : (64'hD00D_0000_0000_0000 | 64'(a));
    endfunction

    // Dual-port RAM with one-cycle registered read and write-through.
    logic [63:0]  ram     [256];
    logic [255:0] ram_wr = '0;
    always @(posedge clk) begin
        if (ram_we_1) begin
            ram[ram_addr_1]    <= ram_wdata_1;
            ram_wr[ram_addr_1] <= 1'b1;
            ram_rdata_1        <= ram_wdata_1;
        end else begin
            ram_rdata_1 <= ram_wr[ram_addr_1] ? ram[ram_addr_1] : init_word(int'(ram_addr_1));
        end
        if (ram_we_2) begin
            ram[ram_addr_2]    <= ram_wdata_2;
            ram_wr[ram_addr_2] <= 1'b1;
            ram_rdata_2        <= ram_wdata_2;
        end else begin
            ram_rdata_2 <= ram_wr[ram_addr_2] ? ram[ram_addr_2] : init_word(int'(ram_addr_2));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [63:0] d);
        req_valid[i]       = 1'b1;
        req_we[i]          = we;
        req_addr[i*A +: A] = a;
        req_wdata[i*W +: W] = d;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
        req_we[i]    = 1'b0;
    endtask

    function automatic logic [63:0] rd(input int i);
        return rsp_rdata[i*W +: W];
    endfunction

    function automatic logic [63:0] st(input int v);
        return STATS ? 64'(v) : 64'd0;
    endfunction

    logic [63:0] shadow  [256];
    logic [63:0] nxt_dat [N];
    logic [N-1:0] nxt_rsp;
    logic [N-1:0] granted;
    int          waitc   [N];
    int          rnd_grants = 0;

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) tick();

        // Reset values
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_we1", ram_we_1, 0);
        chk("rst_addr1", ram_addr_1, 0);
        chk("rst_wdata1", ram_wdata_1, 0);
        chk("rst_we2", ram_we_2, 0);
        chk("rst_addr2", ram_addr_2, 0);
        chk("rst_wdata2", ram_wdata_2, 0);
        chk("rst_grants", stat_grants, 0);
        chk("rst_stalls", stat_stalls, 0);
        set_req(0, 1'b0, 8'h10, 64'd0);
        #1;
        chk("rst_ready_held", req_ready, 0);
        chk("rst_addr1_held", ram_addr_1, 0);

        // First grant right after release
        rst_n = 1'b1;
        #1;
        chk("rel_ready", req_ready, 4'b0001);
        chk("rel_addr1", ram_addr_1, 8'h10);
        chk("rel_we1", ram_we_1, 0);
        chk("rel_addr2", ram_addr_2, 0);
        tick(); clr_req(0);
        chk("rel_rsp", rsp_valid, 4'b0001);
        chk("rel_rdata0", rd(0), init_word(8'h10));

        // Reset mid-read drops the response
        set_req(1, 1'b0, 8'h11, 64'd0);
        #1;
        chk("mid_ready", req_ready, 4'b0010);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_drop", rsp_valid, 0);
        chk("mid_ready_rst", req_ready, 0);
        chk("mid_addr1_rst", ram_addr_1, 0);
        chk("mid_grants_rst", stat_grants, 0);
        tick();
        chk("mid_rsp_after", rsp_valid, 0);
        clr_req(1);
        rst_n = 1'b1;
        #1;

        // Round robin with four continuous readers
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h40 + i), 64'd0);
        #1;
        chk("rr_ready0", req_ready, 4'b0011);
        chk("rr_addr1_0", ram_addr_1, 8'h40);
        chk("rr_addr2_0", ram_addr_2, 8'h41);
        tick();
        chk("rr_rsp0", rsp_valid, 4'b0011);
        chk("rr_rdata0", rd(0), init_word(8'h40));
        chk("rr_rdata1", rd(1), init_word(8'h41));
        chk("rr_ready1", req_ready, 4'b1100);
        chk("rr_addr1_1", ram_addr_1, 8'h42);
        chk("rr_addr2_1", ram_addr_2, 8'h43);
        tick();
        chk("rr_rsp1", rsp_valid, 4'b1100);
        chk("rr_rdata2", rd(2), init_word(8'h42));
        chk("rr_rdata3", rd(3), init_word(8'h43));
        chk("rr_ready2", req_ready, 4'b0011);
        tick();
        chk("rr_rsp2", rsp_valid, 4'b0011);
        for (int i = 0; i < N; i++) clr_req(i);
        #1;
        chk("rr_idle_ready", req_ready, 0);
        tick();
        chk("rr_idle_rsp", rsp_valid, 0);

        // Write hazard defers the read to the same address
        set_req(0, 1'b1, 8'h05, 64'hAA);
        set_req(1, 1'b0, 8'h05, 64'd0);
        #1;
        chk("hz_ready", req_ready, 4'b0001);
        chk("hz_we1", ram_we_1, 1);
        chk("hz_addr1", ram_addr_1, 8'h05);
        chk("hz_wdata1", ram_wdata_1, 64'hAA);
        chk("hz_we2", ram_we_2, 0);
        chk("hz_addr2", ram_addr_2, 0);
        chk("hz_wdata2", ram_wdata_2, 0);
        tick(); clr_req(0);
        chk("hz_no_rsp", rsp_valid, 0);
        chk("hz_stalls", stat_stalls, st(1));
        chk("hz_ready2", req_ready, 4'b0010);
        chk("hz_addr1_2", ram_addr_1, 8'h05);
        tick(); clr_req(1);
        chk("hz_rsp", rsp_valid, 4'b0010);
        chk("hz_rdata1", rd(1), 64'hAA);
        shadow[8'h05] = 64'hAA;

        // Two reads of one address share the cycle
        set_req(2, 1'b0, 8'h20, 64'd0);
        set_req(3, 1'b0, 8'h20, 64'd0);
        #1;
        chk("sh_ready", req_ready, 4'b1100);
        chk("sh_addr1", ram_addr_1, 8'h20);
        chk("sh_addr2", ram_addr_2, 8'h20);
        tick(); clr_req(2); clr_req(3);
        chk("sh_rsp", rsp_valid, 4'b1100);
        chk("sh_rdata2", rd(2), 64'h1234);
        chk("sh_rdata3", rd(3), 64'h1234);
        chk("sh_stalls", stat_stalls, st(1));

        // Wrap: move pointer to 3, then req3 and req0
        set_req(2, 1'b0, 8'h50, 64'd0);
        #1;
        chk("wr_pre_ready", req_ready, 4'b0100);
        tick(); clr_req(2);
        chk("wr_pre_rsp", rsp_valid, 4'b0100);
        set_req(3, 1'b0, 8'h53, 64'd0);
        set_req(0, 1'b0, 8'h60, 64'd0);
        #1;
        chk("wr_ready", req_ready, 4'b1001);
        chk("wr_addr1", ram_addr_1, 8'h53);
        chk("wr_addr2", ram_addr_2, 8'h60);
        tick(); clr_req(3); clr_req(0);
        chk("wr_rsp", rsp_valid, 4'b1001);
        chk("wr_rdata3", rd(3), init_word(8'h53));
        chk("wr_rdata0", rd(0), init_word(8'h60));
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h70 + i), 64'd0);
        #1;
        chk("wr_ptr1_ready", req_ready, 4'b0110);
        tick();
        for (int i = 0; i < N; i++) clr_req(i);
        chk("wr_ptr1_rsp", rsp_valid, 4'b0110);

        // Deferred B stops the scan even though a later requester is clean
        set_req(3, 1'b1, 8'h30, 64'h5555);
        set_req(0, 1'b0, 8'h30, 64'd0);
        set_req(1, 1'b0, 8'h31, 64'd0);
        #1;
        chk("df_ready", req_ready, 4'b1000);
        chk("df_addr2", ram_addr_2, 0);
        tick(); clr_req(3);
        chk("df_stalls", stat_stalls, st(2));
        chk("df_ready2", req_ready, 4'b0011);
        tick(); clr_req(0); clr_req(1);
        chk("df_rsp", rsp_valid, 4'b0011);
        chk("df_rdata0", rd(0), 64'h5555);
        chk("df_rdata1", rd(1), init_word(8'h31));
        chk("df_grants", stat_grants, st(18));
        shadow[8'h30] = 64'h5555;

        // Random traffic: fairness, legal grants and response data
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(1, 0) == 1)) begin
                    set_req(i, 1'($urandom_range(1, 0)), 8'($urandom_range(7, 0)), {$urandom, $urandom});
                    waitc[i] = 0;
                end
            end
            #1;
            chk("rnd_ready_legal", req_ready & ~req_valid, 0);
            nxt_rsp = '0;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    waitc[i]++;
                    if (req_ready[i] || waitc[i] >= N) begin
                        chk("rnd_fair", req_ready[i], 1);
                    end
                    if (req_ready[i]) begin
                        rnd_grants++;
                        if (!req_we[i]) begin
                            nxt_rsp[i] = 1'b1;
                            nxt_dat[i] = shadow[req_addr[i*A +: A]];
                        end
                    end
                end
            end
            granted = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (granted[i] && req_we[i]) shadow[req_addr[i*A +: A]] = req_wdata[i*W +: W];
            end
            tick();
            for (int i = 0; i < N; i++) if (granted[i]) clr_req(i);
            chk("rnd_rsp_valid", rsp_valid, nxt_rsp);
            for (int i = 0; i < N; i++) begin
                if (nxt_rsp[i]) chk("rnd_rdata", rd(i), nxt_dat[i]);
            end
        end
        chk("final_grants", stat_grants, st(18 + rnd_grants));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
